// File: rtl/bidir_bus_responder_pkg.sv
// Shared state encoding, counter width and turnaround limits for the
// half-duplex bus responder.
package bidir_bus_responder_pkg;

    localparam int CNT_W    = 3;
    localparam int TURN_MIN = 1;
    localparam int TURN_MAX = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int turn_cycles_ok(input int tc);
        return ((tc >= TURN_MIN) && (tc <= TURN_MAX)) ? 1 : 0;
    endfunction

endpackage

// File: rtl/bidir_bus_responder_tristate.sv
// Pad-level tristate cell: drives IO from I while OE is high and always
// returns the resolved line value on O.
module bidir_bus_responder_tristate #(
    parameter int width = 16
) (
    input  logic             OE,
    input  logic [width-1:0] I,
    output logic [width-1:0] O,
    inout  wire  [width-1:0] IO
);

    assign IO = OE ? I : {width{1'bz}};
    assign O  = IO;

endmodule

// File: rtl/bidir_bus_responder.sv
// Responder end of a half-duplex parallel bus: a small register bank written
// from BUS_DQ and read back onto BUS_DQ after a programmable turnaround.
module bidir_bus_responder
    import bidir_bus_responder_pkg::*;
#(
    parameter int width      = 16,
    parameter int addrWidth  = 4,
    parameter int turnCycles = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BUS_CS_N,
    input  logic                 BUS_WE_N,
    input  logic [addrWidth-1:0] BUS_ADDR,
    inout  wire  [width-1:0]     BUS_DQ,
    output logic                 BUS_ACK
);

    localparam int DEPTH = 2 ** addrWidth;
    // Equals 1 for a legal turnaround; an illegal one divides by zero at elaboration.
    localparam int TURN_UNIT = 1 / turn_cycles_ok(turnCycles);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(turnCycles - TURN_UNIT);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic [width-1:0]       dout_q, dout_d;
    logic                   oe_q, oe_d;
    logic                   ack_q, ack_d;
    logic [width-1:0]       bank_q [DEPTH];
    logic [width-1:0]       bank_d [DEPTH];
    logic [width-1:0]       din;

    bidir_bus_responder_tristate #(
        .width (width)
    ) u_dq_pad (
        .OE (oe_q),
        .I  (dout_q),
        .O  (din),
        .IO (BUS_DQ)
    );

    assign BUS_ACK = ack_q;

    // Reset clears OE first of all, so the bus is released asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            bank_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!BUS_CS_N) state_d = BUS_WE_N ? TURN : HOLD;
            TURN: begin
                if (BUS_CS_N)           state_d = IDLE;
                else if (cnt_q == '0)   state_d = DRIVE;
            end
            DRIVE:   state_d = BUS_CS_N ? IDLE : HOLD;
            HOLD:    if (BUS_CS_N) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // OE and ACK default low so each strobe lasts exactly one cycle.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        dout_d = dout_q;
        oe_d   = 1'b0;
        ack_d  = 1'b0;
        bank_d = bank_q;
        unique case (state_q)
            IDLE: begin
                if (!BUS_CS_N) begin
                    addr_d = BUS_ADDR;
                    if (!BUS_WE_N) begin
                        bank_d[BUS_ADDR] = din;
                        ack_d            = 1'b1;
                    end else begin
                        cnt_d = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                if (!BUS_CS_N) begin
                    if (cnt_q == '0) begin
                        dout_d = bank_q[addr_q];
                        oe_d   = 1'b1;
                        ack_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bidir_bus_responder.sv
// Directed bench for bidir_bus_responder: three instances cover turnaround
// values 1, 3 and 4 on separate bus segments sharing clock and reset.
module tb_bidir_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n    [3];
    logic        we_n    [3];
    logic [3:0]  addr    [3];
    logic        tb_oe   [3];
    logic [15:0] tb_dout [3];
    logic        ack     [3];
    wire  [15:0] dq_a, dq_b, dq_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dq_a = tb_oe[0] ? tb_dout[0] : 16'hzzzz;
    assign dq_b = tb_oe[1] ? tb_dout[1] : 16'hzzzz;
    assign dq_c = tb_oe[2] ? tb_dout[2] : 16'hzzzz;

    bidir_bus_responder #(.width(16), .addrWidth(4), .turnCycles(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .BUS_CS_N(cs_n[0]), .BUS_WE_N(we_n[0]),
        .BUS_ADDR(addr[0]), .BUS_DQ(dq_a), .BUS_ACK(ack[0]));

    bidir_bus_responder #(.width(16), .addrWidth(4), .turnCycles(3)) dut_b (
        .CLK(clk), .RST_N(rst_n), .BUS_CS_N(cs_n[1]), .BUS_WE_N(we_n[1]),
        .BUS_ADDR(addr[1]), .BUS_DQ(dq_b), .BUS_ACK(ack[1]));

    bidir_bus_responder #(.width(16), .addrWidth(4), .turnCycles(4)) dut_c (
        .CLK(clk), .RST_N(rst_n), .BUS_CS_N(cs_n[2]), .BUS_WE_N(we_n[2]),
        .BUS_ADDR(addr[2]), .BUS_DQ(dq_c), .BUS_ACK(ack[2]));

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] get_dq(input int s);
        case (s)
            0:       return dq_a;
            1:       return dq_b;
            default: return dq_c;
        endcase
    endfunction

    function automatic logic get_oe(input int s);
        case (s)
            0:       return dut_a.oe_q;
            1:       return dut_b.oe_q;
            default: return dut_c.oe_q;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // A released line reads Z in a 4-state simulator and 0 in a 2-state one.
    task automatic check_released(input int s, input string tag);
        logic [15:0] v;
        v = get_dq(s);
        check(tag, {31'd0, (get_oe(s) === 1'b0) && ((v === 16'h0000) || (v === 16'hzzzz))}, 32'd1);
    endtask

    task automatic apply_stimulus(input int s, input logic cs, input logic we, input logic [3:0] a,
                                  input logic drv, input logic [15:0] d);
        cs_n[s]    = cs;
        we_n[s]    = we;
        addr[s]    = a;
        tb_oe[s]   = drv;
        tb_dout[s] = d;
    endtask

    task automatic sample(input int s);
        @(negedge clk);
        check("contention", {31'd0, tb_oe[s] & get_oe(s)}, 32'd0);
    endtask

    task automatic do_write(input int s, input logic [3:0] a, input logic [15:0] d, input string tag);
        apply_stimulus(s, 1'b0, 1'b0, a, 1'b1, d);
        @(posedge clk); #1;
        apply_stimulus(s, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0);
        sample(s);
        check({tag, "_ack"}, {31'd0, ack[s]}, 32'd1);
        @(posedge clk); #1;
        sample(s);
        check({tag, "_ack_end"}, {31'd0, ack[s]}, 32'd0);
    endtask

    task automatic do_read(input int s, input int tc, input logic [3:0] a, input logic [15:0] exp,
                           input string tag);
        apply_stimulus(s, 1'b0, 1'b1, a, 1'b0, 16'h0);
        @(posedge clk); #1;
        for (int k = 0; k < tc; k++) begin
            sample(s);
            check_released(s, {tag, "_turn_z"});
            check({tag, "_turn_ack"}, {31'd0, ack[s]}, 32'd0);
            @(posedge clk); #1;
        end
        sample(s);
        check({tag, "_data"}, {16'd0, get_dq(s)}, {16'd0, exp});
        check({tag, "_ack"}, {31'd0, ack[s]}, 32'd1);
        apply_stimulus(s, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0);
        @(posedge clk); #1;
        sample(s);
        check_released(s, {tag, "_release"});
        check({tag, "_ack_end"}, {31'd0, ack[s]}, 32'd0);
    endtask

    initial begin
        int acks;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(i, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0);

        // Reset state on every instance.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ack", {31'd0, ack[i]}, 32'd0);
            check_released(i, "reset_z");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] turnCycles=1 reset contents, write and read back");
        do_read(0, 1, 4'd3, 16'h0000, "rd3_after_reset");
        do_write(0, 4'd5, 16'hA5C3, "wr5");
        do_read(0, 1, 4'd5, 16'hA5C3, "rd5");

        $display("[TB] reset asserted during DRIVE");
        apply_stimulus(0, 1'b0, 1'b1, 4'd5, 1'b0, 16'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        sample(0);
        check("pre_reset_drive", {16'd0, get_dq(0)}, 32'h0000A5C3);
        rst_n = 1'b0;
        #1;
        check_released(0, "reset_mid_drive_z");
        check("reset_mid_drive_ack", {31'd0, ack[0]}, 32'd0);
        apply_stimulus(0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        do_read(0, 1, 4'd5, 16'h0000, "rd5_after_reset");

        $display("[TB] turnCycles=3 turnaround");
        do_write(1, 4'd0, 16'h1234, "b_wr0");
        do_read(1, 3, 4'd0, 16'h1234, "b_rd0");

        $display("[TB] turnCycles=4 abort");
        do_write(2, 4'd7, 16'hBEEF, "c_wr7");
        apply_stimulus(2, 1'b0, 1'b1, 4'd7, 1'b0, 16'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        apply_stimulus(2, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0);
        for (int k = 0; k < 6; k++) begin
            sample(2);
            check_released(2, "abort_z");
            check("abort_ack", {31'd0, ack[2]}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        do_write(2, 4'd2, 16'h0F0F, "c_wr2_after_abort");
        do_read(2, 4, 4'd2, 16'h0F0F, "c_rd2");
        do_read(2, 4, 4'd7, 16'hBEEF, "c_rd7");

        $display("[TB] hold after write with WE_N toggling");
        acks = 0;
        apply_stimulus(0, 1'b0, 1'b0, 4'd9, 1'b1, 16'h1111);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) apply_stimulus(0, 1'b0, 1'b1, 4'd10, 1'b0, 16'h0);
            else            apply_stimulus(0, 1'b0, 1'b0, 4'd10, 1'b1, 16'h2222);
            sample(0);
            acks += int'(ack[0]);
            @(posedge clk); #1;
        end
        apply_stimulus(0, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0);
        sample(0);
        acks += int'(ack[0]);
        @(posedge clk); #1;
        sample(0);
        acks += int'(ack[0]);
        check("hold_ack_count", acks, 32'd1);
        do_read(0, 1, 4'd9, 16'h1111, "hold_rd9");
        do_read(0, 1, 4'd10, 16'h0000, "hold_rd10");

        $display("[TB] full bank wrap, back-to-back");
        for (int a = 0; a < 16; a++) do_write(0, 4'(a), 16'(a * 16'h1111), "wrap_wr");
        for (int a = 0; a < 16; a++) do_read(0, 1, 4'(a), 16'(a * 16'h1111), "wrap_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
